// File: rtl/fifo_pkg.sv
// Shared FIFO/packer defaults plus lane-count and keep-mask helpers.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH   = 8;
  localparam int unsigned FIFO_DEPTH   = 16;
  localparam int unsigned PACK_DEFAULT = 4;

  // Bits needed to count 0..lanes inclusive.
  function automatic int unsigned cnt_width(input int unsigned lanes);
    return $clog2(lanes + 1);
  endfunction

  // Low n bits set; callers truncate to their lane count.
  function automatic logic [31:0] keep_mask(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle counter that requests a partial-word flush after TIMEOUT_CYCLES quiet cycles.
module packer_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic count_en,
  input  logic clear,
  output logic fire_c
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] idle_cnt;

  assign fire_c = count_en & !clear & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_cnt <= '0;
    end else if (clear || fire_c) begin
      idle_cnt <= '0;
    end else if (count_en) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO and packs PACK lanes into one valid/ready output word.
// Define PACKER_TIMEOUT_EN to flush idle partial words automatically.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = FIFO_WIDTH,
  parameter int unsigned PACK           = PACK_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     fifo_empty_i,
  output logic                     fifo_rd_en_o,
  input  logic [IN_WIDTH-1:0]      fifo_rdata_i,
  input  logic                     flush_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [IN_WIDTH*PACK-1:0] m_data_o,
  output logic [PACK-1:0]          m_keep_o
);

  localparam int unsigned CNT_W  = cnt_width(PACK);
  localparam int unsigned LANE_W = (PACK > 2) ? $clog2(PACK) : 1;

  if (PACK < 2) begin : g_pack_check
    $error("PACK must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [PACK-1:0][IN_WIDTH-1:0] lanes;
  logic [PACK-1:0][IN_WIDTH-1:0] word_full;
  logic [PACK-1:0][IN_WIDTH-1:0] word_part;
  logic [CNT_W-1:0]              cnt;
  logic [CNT_W:0]                fill;
  logic [PACK-1:0]               part_keep;
  logic rd_pend, flush_pend, flush_req;
  logic out_free, word_rdy, load_full, service;

`ifdef PACKER_TIMEOUT_EN
  logic timeout_c;

  packer_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .count_en((cnt != '0) & !rd_pend & !flush_pend),
    .clear   (rd_pend),
    .fire_c  (timeout_c)
  );

  assign flush_req = flush_i | timeout_c;
`else
  assign flush_req = flush_i;
`endif

  // Read/transfer/flush decisions from registered state plus the FIFO flag and ready.
  always_comb begin
    fill         = (CNT_W+1)'(cnt) + (CNT_W+1)'(rd_pend);
    out_free     = !m_valid_o | m_ready_i;
    word_rdy     = (cnt == CNT_W'(PACK)) | ((cnt == CNT_W'(PACK - 1)) & rd_pend);
    fifo_rd_en_o = !fifo_empty_i & !flush_pend &
                   ((fill < (CNT_W+1)'(PACK)) | ((fill == (CNT_W+1)'(PACK)) & out_free));
    load_full    = word_rdy & out_free;
    service      = flush_pend & !rd_pend & (cnt < CNT_W'(PACK)) & out_free;
    part_keep    = PACK'(keep_mask(32'(cnt)));
  end

  // Full word bypasses the last lane straight from the FIFO; partial word zeroes unused lanes.
  always_comb begin
    word_full = lanes;
    if (rd_pend) word_full[PACK-1] = fifo_rdata_i;
    for (int i = 0; i < int'(PACK); i++) begin
      word_part[i] = part_keep[i] ? lanes[i] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lanes      <= '0;
      cnt        <= '0;
      rd_pend    <= 1'b0;
      flush_pend <= 1'b0;
      m_valid_o  <= 1'b0;
      m_data_o   <= '0;
      m_keep_o   <= '0;
    end else begin
      rd_pend <= fifo_rd_en_o;
      if (rd_pend && (cnt < CNT_W'(PACK))) lanes[LANE_W'(cnt)] <= fifo_rdata_i;
      if (m_valid_o && m_ready_i) m_valid_o <= 1'b0;
      if (flush_req && !flush_pend) flush_pend <= 1'b1;

      if (load_full) begin
        m_valid_o <= 1'b1;
        m_data_o  <= word_full;
        m_keep_o  <= '1;
        cnt       <= '0;
      end else if (word_rdy) begin
        cnt <= CNT_W'(PACK);
      end else if (service) begin
        flush_pend <= 1'b0;
        cnt        <= '0;
        if (cnt != '0) begin
          m_valid_o <= 1'b1;
          m_data_o  <= word_part;
          m_keep_o  <= part_keep;
        end
      end else if (rd_pend) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
